// File: rtl/pdh_pkg.sv
// rtl/pdh_pkg.sv - shared state encoding and DAC code constants for the PDH DAC transmitter
package pdh_pkg;

    // Encodings are visible on state_o, so they are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10,
        ST_PARK  = 2'b11
    } pdh_state_t;

    // Signed 14-bit DAC code limits.
    localparam int DAC_CODE_MAX = 8191;
    localparam int DAC_CODE_MIN = -8192;

    // Each DAC channel occupies one 16-bit lane of the output word.
    localparam int LANE_WIDTH = 16;

    // Two's-complement zero is mid-scale on the DAC.
    localparam logic [LANE_WIDTH-1:0] LANE_MID = '0;

endpackage

// File: rtl/pdh_sample_fifo.sv
// rtl/pdh_sample_fifo.sv - two-entry sample-pair buffer with synchronous flush
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   flush       empties the buffer on the next edge; overrides push and pop
//   push        write push_data at the tail (caller guarantees level < 2)
//   push_data   packed sample word to store
//   pop         drop the head (caller guarantees level > 0)
//   pop_data    current head word, valid whenever level > 0
//   level       number of stored entries, 0..2
module pdh_sample_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Push and pop together at level 1 leave the level unchanged.
            level <= level + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/pdh_dac_tx.sv
// rtl/pdh_dac_tx.sv - saturating two-channel sample packer and stream source for the PDH DAC
//
// Ports:
//   clk, rst_n         125 MHz clock, synchronous active-low reset
//   enable             level; run the output stream
//   din_1, din_2       signed channel samples, saturated to 14 bits at push
//   din_valid          input pair offered
//   din_ready          input pair accepted when din_valid is also high
//   M_AXIS_tdata       {ch2 lane, ch1 lane}, each a sign-extended 14-bit code
//   M_AXIS_tvalid      output word valid (RUN and PARK)
//   M_AXIS_tready      DAC sink accepts the word
//   clr_status         pulse; clears underrun_count and sat_seen
//   underrun_count     saturating count of repeated words
//   sat_seen           sticky flag, some pushed sample was clipped
//   state_o            current FSM state code
module pdh_dac_tx
    import pdh_pkg::*;
#(
    parameter int DAC_DATA_WIDTH   = 14,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic signed [SAMPLE_WIDTH-1:0] din_1,
    input  logic signed [SAMPLE_WIDTH-1:0] din_2,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    input  logic                          clr_status,
    output logic [CNT_WIDTH-1:0]          underrun_count,
    output logic                          sat_seen,
    output logic [1:0]                    state_o
);

    localparam logic signed [SAMPLE_WIDTH-1:0] SAT_HI  = SAMPLE_WIDTH'(DAC_CODE_MAX);
    localparam logic signed [SAMPLE_WIDTH-1:0] SAT_LO  = SAMPLE_WIDTH'(DAC_CODE_MIN);
    localparam logic [DAC_DATA_WIDTH-1:0]      CODE_HI = DAC_DATA_WIDTH'(DAC_CODE_MAX);
    localparam logic [DAC_DATA_WIDTH-1:0]      CODE_LO = DAC_DATA_WIDTH'(DAC_CODE_MIN);
    localparam logic [AXIS_TDATA_WIDTH-1:0]    MID_WORD =
        AXIS_TDATA_WIDTH'({LANE_MID, LANE_MID});

    pdh_state_t                  state;
    logic [DAC_DATA_WIDTH-1:0]   code_1;
    logic [DAC_DATA_WIDTH-1:0]   code_2;
    logic                        clip_1;
    logic                        clip_2;
    logic [LANE_WIDTH-1:0]       lane_1;
    logic [LANE_WIDTH-1:0]       lane_2;
    logic [AXIS_TDATA_WIDTH-1:0] push_word;
    logic [AXIS_TDATA_WIDTH-1:0] head_word;
    logic [1:0]                  level;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic                        flush;
    logic                        handshake;
    logic                        underrun_inc;

    // Saturate both channels to the signed 14-bit DAC range.
    always_comb begin
        code_1 = din_1[DAC_DATA_WIDTH-1:0];
        clip_1 = 1'b0;
        if (din_1 > SAT_HI) begin
            code_1 = CODE_HI;
            clip_1 = 1'b1;
        end else if (din_1 < SAT_LO) begin
            code_1 = CODE_LO;
            clip_1 = 1'b1;
        end

        code_2 = din_2[DAC_DATA_WIDTH-1:0];
        clip_2 = 1'b0;
        if (din_2 > SAT_HI) begin
            code_2 = CODE_HI;
            clip_2 = 1'b1;
        end else if (din_2 < SAT_LO) begin
            code_2 = CODE_LO;
            clip_2 = 1'b1;
        end
    end

    assign lane_1    = {{(LANE_WIDTH-DAC_DATA_WIDTH){code_1[DAC_DATA_WIDTH-1]}}, code_1};
    assign lane_2    = {{(LANE_WIDTH-DAC_DATA_WIDTH){code_2[DAC_DATA_WIDTH-1]}}, code_2};
    assign push_word = AXIS_TDATA_WIDTH'({lane_2, lane_1});

    // Ready comes only from registered state and level, so a same-cycle
    // pop never opens a slot for a push.
    assign din_ready  = (state != ST_IDLE) && (level < 2'd2);
    assign fifo_empty = (level == 2'd0);
    assign push       = din_valid && din_ready;
    assign handshake  = M_AXIS_tvalid && M_AXIS_tready;

    assign pop = ((state == ST_PRIME) && enable && !fifo_empty) ||
                 ((state == ST_RUN) && handshake && enable && !fifo_empty);

    // Every way into IDLE discards buffered samples.
    assign flush = ((state == ST_PRIME) && !enable) ||
                   ((state == ST_PARK) && handshake);

    assign underrun_inc = (state == ST_RUN) && handshake && enable && fifo_empty;

    pdh_sample_fifo #(
        .WIDTH (AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            M_AXIS_tdata   <= '0;
            M_AXIS_tvalid  <= 1'b0;
            underrun_count <= '0;
            sat_seen       <= 1'b0;
        end else begin
            // Clear beats a coincident increment or clip.
            if (clr_status) begin
                underrun_count <= '0;
                sat_seen       <= 1'b0;
            end else begin
                if (underrun_inc && (underrun_count != {CNT_WIDTH{1'b1}})) begin
                    underrun_count <= underrun_count + 1'b1;
                end
                if (push && (clip_1 || clip_2)) begin
                    sat_seen <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (!fifo_empty) begin
                        M_AXIS_tdata  <= head_word;
                        M_AXIS_tvalid <= 1'b1;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The current word is only replaced on a handshake, so a
                    // disable waits for the sink rather than retracting data.
                    if (handshake) begin
                        if (!enable) begin
                            M_AXIS_tdata <= MID_WORD;
                            state        <= ST_PARK;
                        end else if (!fifo_empty) begin
                            M_AXIS_tdata <= head_word;
                        end
                    end
                end
                ST_PARK: begin
                    if (handshake) begin
                        M_AXIS_tvalid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pdh_dac_tx.sv
// tb/tb_pdh_dac_tx.sv - directed and randomized checks of pdh_dac_tx against a queue-based model
module tb_pdh_dac_tx;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic signed [15:0] din_1;
    logic signed [15:0] din_2;
    logic               din_valid;
    logic               din_ready;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               clr_status;
    logic [15:0]        underrun_count;
    logic               sat_seen;
    logic [1:0]         state_o;

    always #4 clk = ~clk;

    pdh_dac_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .din_1          (din_1),
        .din_2          (din_2),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .M_AXIS_tdata   (m_axis_tdata),
        .M_AXIS_tvalid  (m_axis_tvalid),
        .M_AXIS_tready  (m_axis_tready),
        .clr_status     (clr_status),
        .underrun_count (underrun_count),
        .sat_seen       (sat_seen),
        .state_o        (state_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode number, pending pairs as a queue, current word.
    int          m_mode;
    logic [31:0] m_q[$];
    logic [31:0] m_word;
    bit          m_valid;
    int          m_under;
    bit          m_sat;

    function automatic logic [15:0] lane_of(input int v, output bit clipped);
        int c;
        c = (v > 8191) ? 8191 : ((v < -8192) ? -8192 : v);
        clipped = (c != v);
        return c[15:0];
    endfunction

    task automatic model_step(input bit en, input int v1, input int v2,
                              input bit dv, input bit tr, input bit clr, input bit rstn);
        bit          c1, c2, rdy, push, hs, flush;
        int          n;
        logic [15:0] l1, l2;
        if (!rstn) begin
            m_mode  = 0;
            m_q.delete();
            m_word  = 32'h0;
            m_valid = 1'b0;
            m_under = 0;
            m_sat   = 1'b0;
            return;
        end
        l1    = lane_of(v1, c1);
        l2    = lane_of(v2, c2);
        n     = m_q.size();
        rdy   = (m_mode != 0) && (n < 2);
        push  = dv && rdy;
        hs    = m_valid && tr;
        flush = 1'b0;
        if (clr) begin
            m_under = 0;
            m_sat   = 1'b0;
        end else begin
            if (m_mode == 2 && hs && en && n == 0 && m_under < 65535) m_under++;
            if (push && (c1 || c2)) m_sat = 1'b1;
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
                if (!en) begin
                    m_mode = 0;
                    flush  = 1'b1;
                end else if (n > 0) begin
                    m_word  = m_q.pop_front();
                    m_valid = 1'b1;
                    m_mode  = 2;
                end
            end
            2: begin
                if (hs) begin
                    if (!en) begin
                        m_mode = 3;
                        m_word = 32'h0;
                    end else if (n > 0) begin
                        m_word = m_q.pop_front();
                    end
                end
            end
            default: begin
                if (hs) begin
                    m_mode  = 0;
                    m_valid = 1'b0;
                    flush   = 1'b1;
                end
            end
        endcase
        if (flush) m_q.delete();
        else if (push) m_q.push_back({l2, l1});
    endtask

    task automatic check_all();
        chk("tvalid", {31'h0, m_axis_tvalid}, {31'h0, m_valid});
        chk("tdata", m_axis_tdata, m_word);
        chk("state", {30'h0, state_o}, m_mode);
        chk("din_ready", {31'h0, din_ready}, {31'h0, (m_mode != 0) && (m_q.size() < 2)});
        chk("underrun", {16'h0, underrun_count}, m_under);
        chk("sat_seen", {31'h0, sat_seen}, {31'h0, m_sat});
    endtask

    // One clock: drive at the falling edge, advance the model, sample at the next falling edge.
    task automatic cyc(input bit en, input int v1, input int v2,
                       input bit dv, input bit tr, input bit clr, input bit rstn);
        enable        = en;
        din_1         = 16'(v1);
        din_2         = 16'(v2);
        din_valid     = dv;
        m_axis_tready = tr;
        clr_status    = clr;
        rst_n         = rstn;
        model_step(en, v1, v2, dv, tr, clr, rstn);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic int rnd_sample();
        logic signed [15:0] r;
        int                 sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 2) begin
            r = 16'($urandom);
            return int'(r);
        end else if (sel == 2) begin
            case ($urandom_range(0, 3))
                0:       return 8191;
                1:       return 8192;
                2:       return -8192;
                default: return -8193;
            endcase
        end
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    initial begin
        bit en;
        @(negedge clk);

        // Reset state
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_ready", {31'h0, din_ready}, 32'h0);

        // First word latency and packing
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("prime_state", {30'h0, state_o}, 32'h1);
        cyc(1, 100, -200, 1, 1, 0, 1);
        chk("lat_c1_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("lat_c2_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
        chk("first_word", m_axis_tdata, 32'hFF380064);

        // Underrun repeats
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0, 1);
        chk("under5_count", {16'h0, underrun_count}, 32'd5);
        chk("under5_word", m_axis_tdata, 32'hFF380064);

        // Clipping
        cyc(1, 20000, -20000, 1, 0, 0, 1);
        chk("clip_sat", {31'h0, sat_seen}, 32'h1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("clip_word", m_axis_tdata, 32'hE0001FFF);

        // Backpressure: three pairs offered, two fit
        cyc(1, 1, 2, 1, 0, 0, 1);
        chk("bp_hold", m_axis_tdata, 32'hE0001FFF);
        cyc(1, 3, 4, 1, 0, 0, 1);
        chk("bp_hold", m_axis_tdata, 32'hE0001FFF);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 5, 6, 1, 0, 0, 1);
            chk("bp_hold", m_axis_tdata, 32'hE0001FFF);
        end
        chk("bp_full_ready", {31'h0, din_ready}, 32'h0);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("bp_drain_a", m_axis_tdata, 32'h00020001);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("bp_drain_b", m_axis_tdata, 32'h00040003);

        // Disable in RUN: one mid-scale word, then idle
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("park_word", m_axis_tdata, 32'h0);
        chk("park_state", {30'h0, state_o}, 32'h3);
        cyc(0, 0, 0, 0, 1, 0, 1);
        chk("park_done_valid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("park_done_state", {30'h0, state_o}, 32'h0);
        chk("park_done_ready", {31'h0, din_ready}, 32'h0);

        // Disable in PRIME returns straight to IDLE
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("prime_abort", {30'h0, state_o}, 32'h0);

        // Reset mid-stream with underrun_count = 7
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 7, 8, 1, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 1, 0, 1);
        chk("pre_rst_count", {16'h0, underrun_count}, 32'd7);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("mid_rst_count", {16'h0, underrun_count}, 32'h0);
        chk("mid_rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("mid_rst_tdata", m_axis_tdata, 32'h0);
        chk("mid_rst_state", {30'h0, state_o}, 32'h0);

        // Clear against a coincident underrun and a coincident clip
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 9, 9, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        chk("clr_pre_count", {16'h0, underrun_count}, 32'd1);
        cyc(1, 0, 0, 0, 1, 1, 1);
        chk("clr_vs_under", {16'h0, underrun_count}, 32'h0);
        cyc(1, 30000, 0, 1, 0, 1, 1);
        chk("clr_vs_clip", {31'h0, sat_seen}, 32'h0);

        // Randomized traffic
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            cyc(en, rnd_sample(), rnd_sample(),
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 299) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdh_dac_tx.md
PDH_DAC_TX -- requirements
Module: pdh_dac_tx

Interface
REQ-001 SHALL have parameter DAC_DATA_WIDTH, default 14, the DAC code width per channel.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, the signed width of each processed input sample.
REQ-003 SHALL have parameter AXIS_TDATA_WIDTH, default 32, the packed two-channel output word width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, the underrun counter width.
REQ-005 SHALL provide ports:
- clk  in  1  system clock (FCLK_CLK0, 125 MHz); one clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  level; run the output stream.
- din_1  in  SAMPLE_WIDTH  channel-1 sample, signed.
- din_2  in  SAMPLE_WIDTH  channel-2 sample, signed.
- din_valid  in  1  input sample pair valid.
- din_ready  out  1  input sample pair accepted when din_valid is also high.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  {ch2 lane, ch1 lane}; ch1 in [15:0], ch2 in [31:16].
- M_AXIS_tvalid  out  1  output word valid.
- M_AXIS_tready  in  1  DAC sink accepts the word.
- clr_status  in  1  single-cycle pulse; clears underrun_count and sat_seen.
- underrun_count  out  CNT_WIDTH  saturating count of underrun repeats.
- sat_seen  out  1  sticky; some input sample was clipped.
- state_o  out  2  current FSM state code.

Function
REQ-006 SHALL saturate each input sample at FIFO push to the signed 14-bit range: >8191 becomes 8191, <-8192 becomes -8192, anything else passes unchanged.
REQ-007 SHALL set sat_seen on the cycle after any push in which either channel clipped.
REQ-008 SHALL build each 16-bit lane as the 14-bit code sign-extended into bits [15:14].
REQ-009 SHALL buffer sample pairs in a 2-entry FIFO.
REQ-010 SHALL drive din_ready = (state != IDLE) AND (fifo level < 2), derived only from registered state; a pop does not free space in the same cycle.
REQ-011 SHALL implement the FSM states and transitions below:
- IDLE (00): on enable=1, go to PRIME.
- PRIME (01): on fifo non-empty, load the head into the output register and go to RUN.
- RUN (10): on enable=0, go to PARK.
- PARK (11): after one handshake, go to IDLE.
REQ-012 SHALL hold M_AXIS_tvalid=0 in IDLE and PRIME, and M_AXIS_tvalid=1 in RUN and PARK.
REQ-013 SHALL reach M_AXIS_tvalid=1 two cycles after the first input handshake when starting from PRIME with an empty FIFO.
REQ-014 SHALL keep M_AXIS_tdata stable while tvalid=1 and tready=0.
REQ-015 SHALL, on a RUN handshake with the FIFO non-empty, pop the head into the output register on the next edge.
REQ-016 SHALL, on a RUN handshake with the FIFO empty, repeat the last word and increment underrun_count, saturating at all-ones.
REQ-017 SHALL, on entering PARK, drive M_AXIS_tdata to 0 (mid-scale) and hold it until handshake.
REQ-018 SHALL flush the FIFO on entering IDLE.
REQ-019 SHALL let enable=0 in PRIME go directly to IDLE.
REQ-020 SHALL restart through PRIME when enable=1 arrives during PARK, after PARK completes.
REQ-021 SHALL, when clr_status coincides with an underrun increment or a clip, make clear win: both outputs read 0 on the next cycle.
REQ-022 SHALL accept a simultaneous push and pop at level 1, leaving the level at 1 with correct ordering.

Reset
REQ-023 SHALL, with rst_n=0 at an edge, set state IDLE, fifo empty, M_AXIS_tvalid=0, M_AXIS_tdata=0, din_ready=0, underrun_count=0, sat_seen=0 and state_o=00.
REQ-024 SHALL, on reset mid-stream, drop any in-flight word without a handshake, even if tready is high.

Structure
REQ-025 SHALL place the FSM state encoding, DAC code limits (8191, -8192), lane width 16 and the mid-scale code in shared package pdh_pkg.
REQ-026 SHALL implement the 2-entry buffer as sub-module pdh_sample_fifo, with push/pop/level and a synchronous flush.

Verification
REQ-027 SHALL cover: enable=1, push (100,-200), tready=1 -> tvalid rises 2 cycles later, tdata=0xFF380064.
REQ-028 SHALL cover: push din_1=20000, din_2=-20000 -> tdata=0xE0001FFF, and sat_seen=1 next cycle.
REQ-029 SHALL cover: RUN with tready=1 and no further input for 5 cycles -> last word repeated, underrun_count=5.
REQ-030 SHALL cover: tready=0 for 10 cycles with 3 pushes offered -> tdata stable, din_ready=0 after FIFO holds 2, no data loss once tready=1.
REQ-031 SHALL cover: drop enable in RUN -> one 0x00000000 word handshaked, then tvalid=0, state_o=00, din_ready=0.
REQ-032 SHALL cover: rst_n=0 mid-stream with underrun_count=7 -> all outputs at reset values after one edge; clr_status coinciding with an underrun -> count=0.
